smg595_clock_scan: RTL and testbench
====================================

Name: smg595_clock_scan

Overview:
- Parametrised successor to the single-purpose seven-segment clock driver.
- Keeps a BCD time-of-day (HH:MM:SS) from a 1 s prescaler of clk.
- Multiplexes up to 8 digits through a cascaded 74HC595 pair (segment byte + digit-select byte) over a 3-wire serial link.
- Adds run/hold, synchronous time load, 12/24 h mode, configurable shift rate and output polarity.

Parameters:
MAX_CNT, 50_000_000, clk cycles per second; must be >= 2
SHIFT_DIV, 4, clk cycles per half-period of ds_shcp; must be >= 1
DIGITS, 6, digits scanned, 1..8; digit 0 is the rightmost (seconds units)
HOUR_24, 1, 1 = 00..23 hours; 0 = 01..12 hours
SEG_ACTIVE_LOW, 1, 1 = invert the segment byte (common anode)
SEL_ACTIVE_LOW, 1, 1 = invert the digit-select byte

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
run  in  1  1 = time advances; 0 = hold time and prescaler
set_en  in  1  one-cycle load strobe
set_hh  in  8  BCD hours for load
set_mm  in  8  BCD minutes for load
set_ss  in  8  BCD seconds for load
ds_data  out  1  595 serial data
ds_shcp  out  1  595 shift clock
ds_stcp  out  1  595 storage (latch) clock
sec_tick  out  1  one-cycle pulse on each time increment

Behaviour:
- Clocking and reset:
  - Single clock domain; all state on clk rising edge; rst asynchronous, active-high.
  - Reset values: ds_data=0, ds_shcp=0, ds_stcp=0, sec_tick=0; prescaler=0.
  - Time after reset: 00:00:00 when HOUR_24=1, 12:00:00 when HOUR_24=0.
  - Scan FSM returns to LOAD with digit index 0.
- Prescaler:
  - Counts 0..MAX_CNT-1 while run=1; holds while run=0.
  - At the terminal count it wraps to 0 and sec_tick=1 for exactly that cycle.
  - The time increments on the same edge.
- Time counting (BCD):
  - ss 59->00 carries to mm; mm 59->00 carries to hh.
  - hh 23->00 when HOUR_24=1; hh 12->01 when HOUR_24=0.
  - All carries resolve in one cycle, so 23:59:59 -> 00:00:00 in a single tick.
- Load:
  - set_en=1 loads hh/mm/ss and clears the prescaler. Load has priority over a simultaneous tick; sec_tick still pulses but the loaded value wins.
  - A load is ignored entirely (no field changes, prescaler not cleared) if any nibble >9, ss>0x59, mm>0x59, or hh is out of range for the mode (>0x23; or 0x00 / >0x12 in 12 h mode).
- Digit mapping:
  - 0 = ss units, 1 = ss tens, 2 = mm units, 3 = mm tens, 4 = hh units, 5 = hh tens.
  - Digits 6,7 are blank (segments off).
  - Decimal point is lit on digits 2 and 4 as separators.
- Segment encoding:
  - Byte bit7=dp, bits6..0=gfedcba, active-high before polarity inversion.
  - Digits 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F.
  - Select byte = one-hot (1<<d) before polarity inversion.
- Scan FSM:
  - LOAD (1 cycle): snapshot frame = {seg_byte, sel_byte} for the current digit; bit counter=15.
  - SHIFT: for each of 16 bits, MSB first:
    - ds_data presents the bit and ds_shcp is held low for SHIFT_DIV cycles.
    - ds_shcp is then high for SHIFT_DIV cycles, with ds_data stable.
    - After bit 0 completes, go to LATCH.
  - LATCH: ds_shcp=0, ds_stcp high for SHIFT_DIV cycles, then low. Digit index increments, wrapping DIGITS-1 -> 0, and the FSM returns to LOAD.
  - Period per digit = 33*SHIFT_DIV+1 cycles.
  - ds_data=0 whenever not in SHIFT.
  - ds_shcp and ds_stcp are never high simultaneously.
- Consistency and abort:
  - A time change mid-frame does not alter the frame in flight.
  - Reset mid-frame aborts immediately with no partial latch pulse.

Test Plan:
- Reset check (SHIFT_DIV=2, DIGITS=6): hold rst 5 cycles -> all outputs 0. First frame for digit 0 at 00:00:00 shifts 0xC0 then 0xFE (active-low), 16 shcp rising edges, one stcp pulse of 2 cycles; next LOAD 67 cycles after the first.
- Rollover (MAX_CNT=50): load 23:59:59 -> after 50 cycles sec_tick=1 and time = 00:00:00. Digit 4 frame then shows 0x40 (0 with dp, inverted) and sel 0xEF.
- 12 h mode: load 12:59:59 -> one tick -> 01:00:00. Load hh=0x13 -> ignored, time unchanged.
- Simultaneous events: assert set_en=1 (10:20:30) on the prescaler terminal cycle -> time 10:20:30, sec_tick=1, prescaler 0. With run=0 for 200 cycles -> time constant, no sec_tick.
- Invalid load: set_ss=0x5A -> no change, prescaler keeps counting.
- Reset mid-operation: assert rst during SHIFT bit 7 of digit 3 -> outputs 0 within the same cycle (async). After release, scanning restarts at digit 0 with time 00:00:00.

Source files
------------

// File: rtl/smg595_clock_scan.sv
// BCD time-of-day clock driving a cascaded 74HC595 pair (segment byte + digit-select byte).
// Each frame shifts {seg, sel} MSB first over a 3-wire link, then pulses the storage clock.
module smg595_clock_scan #(
  parameter int unsigned MAX_CNT        = 50_000_000,
  parameter int unsigned SHIFT_DIV      = 4,
  parameter int unsigned DIGITS         = 6,
  parameter bit          HOUR_24        = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       set_en,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  output logic       ds_data,
  output logic       ds_shcp,
  output logic       ds_stcp,
  output logic       sec_tick
);

  localparam int unsigned PW = $clog2(MAX_CNT);
  localparam int unsigned DW = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;

  typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_LATCH} state_t;

  logic [PW-1:0] r_pre;
  logic          r_tick;
  logic [7:0]    r_hh, r_mm, r_ss;
  logic [7:0]    w_hh_inc, w_mm_inc, w_ss_inc;
  logic          w_tc, w_load, w_bcd_ok, w_hh_ok;

  state_t        r_state, w_state_n;
  logic [15:0]   r_frame;
  logic [3:0]    r_bit;
  logic [DW-1:0] r_div;
  logic          r_phase;
  logic [2:0]    r_dig;
  logic          w_div_end;
  logic [3:0]    w_nib;
  logic          w_blank;
  logic [7:0]    w_pat, w_seg, w_sel;
  logic [15:0]   w_frame;

  assign w_tc     = run && (r_pre == PW'(MAX_CNT - 1));
  assign w_bcd_ok = (set_hh[3:0] <= 4'd9) && (set_hh[7:4] <= 4'd9) &&
                    (set_mm[3:0] <= 4'd9) && (set_mm[7:4] <= 4'd9) &&
                    (set_ss[3:0] <= 4'd9) && (set_ss[7:4] <= 4'd9) &&
                    (set_mm <= 8'h59) && (set_ss <= 8'h59);
  assign w_hh_ok  = HOUR_24 ? (set_hh <= 8'h23) : ((set_hh != 8'h00) && (set_hh <= 8'h12));
  assign w_load   = set_en && w_bcd_ok && w_hh_ok;
  assign sec_tick = r_tick;

  // Full ripple of the BCD carry chain in one cycle.
  always_comb begin
    w_ss_inc = r_ss;
    w_mm_inc = r_mm;
    w_hh_inc = r_hh;
    if (r_ss[3:0] != 4'd9) begin
      w_ss_inc[3:0] = r_ss[3:0] + 4'd1;
    end else if (r_ss[7:4] != 4'd5) begin
      w_ss_inc = {r_ss[7:4] + 4'd1, 4'd0};
    end else begin
      w_ss_inc = '0;
      if (r_mm[3:0] != 4'd9) begin
        w_mm_inc[3:0] = r_mm[3:0] + 4'd1;
      end else if (r_mm[7:4] != 4'd5) begin
        w_mm_inc = {r_mm[7:4] + 4'd1, 4'd0};
      end else begin
        w_mm_inc = '0;
        if (HOUR_24 && (r_hh == 8'h23))        w_hh_inc = 8'h00;
        else if (!HOUR_24 && (r_hh == 8'h12))  w_hh_inc = 8'h01;
        else if (r_hh[3:0] == 4'd9)            w_hh_inc = {r_hh[7:4] + 4'd1, 4'd0};
        else                                   w_hh_inc[3:0] = r_hh[3:0] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
      r_hh   <= HOUR_24 ? 8'h00 : 8'h12;
      r_mm   <= '0;
      r_ss   <= '0;
    end else begin
      r_tick <= w_tc;
      if (w_load) begin
        r_pre <= '0;
        r_hh  <= set_hh;
        r_mm  <= set_mm;
        r_ss  <= set_ss;
      end else if (w_tc) begin
        r_pre <= '0;
        r_hh  <= w_hh_inc;
        r_mm  <= w_mm_inc;
        r_ss  <= w_ss_inc;
      end else if (run) begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  always_comb begin
    w_nib   = 4'd0;
    w_blank = 1'b0;
    case (r_dig)
      3'd0:    w_nib = r_ss[3:0];
      3'd1:    w_nib = r_ss[7:4];
      3'd2:    w_nib = r_mm[3:0];
      3'd3:    w_nib = r_mm[7:4];
      3'd4:    w_nib = r_hh[3:0];
      3'd5:    w_nib = r_hh[7:4];
      default: w_blank = 1'b1;
    endcase
    case (w_nib)
      4'd0:    w_pat = 8'h3F;
      4'd1:    w_pat = 8'h06;
      4'd2:    w_pat = 8'h5B;
      4'd3:    w_pat = 8'h4F;
      4'd4:    w_pat = 8'h66;
      4'd5:    w_pat = 8'h6D;
      4'd6:    w_pat = 8'h7D;
      4'd7:    w_pat = 8'h07;
      4'd8:    w_pat = 8'h7F;
      4'd9:    w_pat = 8'h6F;
      default: w_pat = 8'h00;
    endcase
    w_seg = w_blank ? 8'h00 : {(r_dig == 3'd2) || (r_dig == 3'd4), w_pat[6:0]};
    w_sel = 8'd1 << r_dig;
    w_frame = {SEG_ACTIVE_LOW ? ~w_seg : w_seg, SEL_ACTIVE_LOW ? ~w_sel : w_sel};
  end

  assign w_div_end = (r_div == DW'(SHIFT_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_LOAD:  w_state_n = S_SHIFT;
      S_SHIFT: if (w_div_end && r_phase && (r_bit == 4'd0)) w_state_n = S_LATCH;
      S_LATCH: if (w_div_end) w_state_n = S_LOAD;
      default: w_state_n = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame <= '0;
      r_bit   <= 4'd15;
      r_div   <= '0;
      r_phase <= 1'b0;
      r_dig   <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_frame <= w_frame;
          r_bit   <= 4'd15;
          r_div   <= '0;
          r_phase <= 1'b0;
        end
        S_SHIFT: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_phase <= ~r_phase;
            if (r_phase) r_bit <= r_bit - 4'd1;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_LATCH: begin
          if (w_div_end) begin
            r_div <= '0;
            r_dig <= (r_dig == 3'(DIGITS - 1)) ? 3'd0 : r_dig + 3'd1;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: r_div <= '0;
      endcase
    end
  end

  always_comb begin
    ds_data = 1'b0;
    ds_shcp = 1'b0;
    ds_stcp = 1'b0;
    case (r_state)
      S_SHIFT: begin
        ds_data = r_frame[r_bit];
        ds_shcp = r_phase;
      end
      S_LATCH: ds_stcp = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_smg595_clock_scan.sv
// Bench for smg595_clock_scan: a 595-pair receiver model decodes latched frames and
// compares them against expected frames queued by the stimulus.
module tb_smg595_clock_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [1:0] set_en = '0;
  logic [7:0] set_hh = '0, set_mm = '0, set_ss = '0;
  logic [1:0] ds_data, ds_shcp, ds_stcp, sec_tick;

  always #5 clk = ~clk;

  smg595_clock_scan #(.MAX_CNT(50), .SHIFT_DIV(2), .DIGITS(6), .HOUR_24(1'b1),
                      .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) u_dut24 (
    .clk(clk), .rst(rst), .run(run), .set_en(set_en[0]),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .ds_data(ds_data[0]), .ds_shcp(ds_shcp[0]), .ds_stcp(ds_stcp[0]), .sec_tick(sec_tick[0]));

  smg595_clock_scan #(.MAX_CNT(50), .SHIFT_DIV(2), .DIGITS(6), .HOUR_24(1'b0),
                      .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) u_dut12 (
    .clk(clk), .rst(rst), .run(run), .set_en(set_en[1]),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .ds_data(ds_data[1]), .ds_shcp(ds_shcp[1]), .ds_stcp(ds_stcp[1]), .sec_tick(sec_tick[1]));

  typedef struct { int dut; int dig; logic [15:0] exp; } exp_t;
  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0] sh[2];
  int nsh[2], dig[2], hi[2], last[2], n_latch[2];
  bit have[2], p_shcp[2], p_stcp[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_frame(input logic [7:0] hh, input logic [7:0] mm,
                                            input logic [7:0] ss, input int d);
    logic [3:0] nib;
    logic [7:0] seg, sel;
    case (d)
      0: nib = ss[3:0];
      1: nib = ss[7:4];
      2: nib = mm[3:0];
      3: nib = mm[7:4];
      4: nib = hh[3:0];
      default: nib = hh[7:4];
    endcase
    case (nib)
      4'd0: seg = 8'h3F; 4'd1: seg = 8'h06; 4'd2: seg = 8'h5B; 4'd3: seg = 8'h4F;
      4'd4: seg = 8'h66; 4'd5: seg = 8'h6D; 4'd6: seg = 8'h7D; 4'd7: seg = 8'h07;
      4'd8: seg = 8'h7F; default: seg = 8'h6F;
    endcase
    if (d == 2 || d == 4) seg[7] = 1'b1;
    sel = 8'h01 << d;
    return {~seg, ~sel};
  endfunction

  task automatic push_scan(input int g, input logic [7:0] hh, input logic [7:0] mm,
                           input logic [7:0] ss);
    for (int d = 0; d < 6; d++) q.push_back('{g, d, exp_frame(hh, mm, ss, d)});
  endtask

  // 595 receiver model: shift on shcp rise, latch on stcp rise.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (rst) begin
          sh[g] = '0; nsh[g] = 0; dig[g] = 0; hi[g] = 0; have[g] = 1'b0;
        end else begin
          if (ds_shcp[g] && !p_shcp[g]) begin
            sh[g] = {sh[g][14:0], ds_data[g]};
            nsh[g]++;
          end
          if (ds_stcp[g] && !p_stcp[g]) begin
            chk($sformatf("shcp edges per frame dut%0d", g), nsh[g], 16);
            chk($sformatf("data/shcp idle in latch dut%0d", g), {ds_data[g], ds_shcp[g]}, 0);
            if (have[g]) chk($sformatf("frame period dut%0d", g), cyc - last[g], 67);
            if (q.size() > 0 && q[0].dut == g && q[0].dig == dig[g]) begin
              e = q.pop_front();
              chk($sformatf("frame dut%0d digit%0d", g, e.dig), sh[g], e.exp);
            end
            dig[g] = (dig[g] + 1) % 6;
            nsh[g] = 0;
            last[g] = cyc;
            have[g] = 1'b1;
            n_latch[g]++;
          end
          if (ds_stcp[g]) hi[g]++;
          else if (p_stcp[g]) begin
            chk($sformatf("stcp width dut%0d", g), hi[g], 2);
            hi[g] = 0;
          end
        end
        p_shcp[g] = ds_shcp[g];
        p_stcp[g] = ds_stcp[g];
      end
    end
  endtask

  task automatic load(input int g, input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
    set_hh = hh; set_mm = mm; set_ss = ss;
    set_en[g] = 1'b1;
    @(negedge clk);
    set_en = '0;
  endtask

  task automatic run_until_tick(input int g, input int exp_edges, input string nm);
    int k = 0;
    run = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (!sec_tick[g] && k < 200);
    run = 1'b0;
    chk(nm, k, exp_edges);
  endtask

  task automatic wait_boundary(input int g);
    int c = n_latch[g];
    int k = 0;
    while (n_latch[g] == c && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("frame boundary seen", n_latch[g] != c, 1);
  endtask

  task automatic wait_empty(input string nm);
    int k = 0;
    while (q.size() > 0 && k < 1500) begin
      @(negedge clk);
      k++;
    end
    chk(nm, q.size(), 0);
    q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    int k;
    fork
      monitor();
    join_none

    // Reset state and first scan
    repeat (5) @(negedge clk);
    chk("reset outputs dut24", {ds_data[0], ds_shcp[0], ds_stcp[0], sec_tick[0]}, 0);
    chk("reset outputs dut12", {ds_data[1], ds_shcp[1], ds_stcp[1], sec_tick[1]}, 0);
    push_scan(0, 8'h00, 8'h00, 8'h00);
    push_scan(1, 8'h12, 8'h00, 8'h00);
    rst = 1'b0;
    wait_empty("reset scan drained");

    // Full carry rollover
    load(0, 8'h23, 8'h59, 8'h59);
    run_until_tick(0, 50, "rollover tick latency");
    @(negedge clk);
    chk("tick single cycle", sec_tick[0], 0);
    wait_boundary(0);
    push_scan(0, 8'h00, 8'h00, 8'h00);
    wait_empty("rollover scan drained");

    // Load coinciding with terminal count, then hold
    run = 1'b1;
    ticks = 0;
    repeat (49) begin
      @(negedge clk);
      if (sec_tick[0]) ticks++;
    end
    chk("no early tick", ticks, 0);
    set_hh = 8'h10; set_mm = 8'h20; set_ss = 8'h30;
    set_en[0] = 1'b1;
    @(negedge clk);
    set_en = '0;
    run = 1'b0;
    chk("tick with load", sec_tick[0], 1);
    ticks = 0;
    repeat (200) begin
      @(negedge clk);
      if (sec_tick[0]) ticks++;
    end
    chk("no tick while held", ticks, 0);
    wait_boundary(0);
    push_scan(0, 8'h10, 8'h20, 8'h30);
    wait_empty("load-wins scan drained");
    run_until_tick(0, 50, "prescaler zero after load");

    // Invalid loads mid-count: time and prescaler untouched
    run = 1'b1;
    repeat (20) @(negedge clk);
    load(0, 8'h10, 8'h20, 8'h5A);
    load(0, 8'h10, 8'h60, 8'h30);
    load(0, 8'h24, 8'h20, 8'h30);
    load(0, 8'h1A, 8'h20, 8'h30);
    run_until_tick(0, 26, "invalid load keeps prescaler");
    wait_boundary(0);
    push_scan(0, 8'h10, 8'h20, 8'h32);
    wait_empty("invalid load scan drained");

    // Valid load mid-count clears prescaler
    run = 1'b1;
    repeat (20) @(negedge clk);
    load(0, 8'h01, 8'h02, 8'h03);
    run_until_tick(0, 50, "valid load clears prescaler");
    wait_boundary(0);
    push_scan(0, 8'h01, 8'h02, 8'h04);
    wait_empty("mid-count load scan drained");

    // 12 h mode
    load(1, 8'h12, 8'h59, 8'h59);
    run_until_tick(1, 50, "12h tick latency");
    wait_boundary(1);
    push_scan(1, 8'h01, 8'h00, 8'h00);
    wait_empty("12h wrap scan drained");
    load(1, 8'h13, 8'h00, 8'h00);
    load(1, 8'h00, 8'h30, 8'h30);
    wait_boundary(1);
    push_scan(1, 8'h01, 8'h00, 8'h00);
    wait_empty("12h invalid hour scan drained");
    load(1, 8'h11, 8'h59, 8'h59);
    run_until_tick(1, 50, "12h 11->12 tick");
    wait_boundary(1);
    push_scan(1, 8'h12, 8'h00, 8'h00);
    wait_empty("12h 11->12 scan drained");

    // Reset during the shift of digit 3
    k = 0;
    while (!(dig[0] == 3 && ds_stcp[0]) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("reached digit 3", dig[0], 3);
    repeat (36) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async reset outputs", {ds_data[0], ds_shcp[0], ds_stcp[0], sec_tick[0]}, 0);
    repeat (3) @(negedge clk);
    push_scan(0, 8'h00, 8'h00, 8'h00);
    push_scan(1, 8'h12, 8'h00, 8'h00);
    rst = 1'b0;
    wait_empty("post-reset scan drained");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
